// File: rtl/multiport_memory_controller.sv
// multiport_memory_controller
// Byte-addressed on-chip RAM shared by several request channels. One
// transaction is granted at a time (fixed priority or round-robin) and is
// serialised one byte per cycle, little-endian, with starting / completing /
// complete pulses reported on the granted channel.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | no transaction; arbitrate and latch the winner's request
//   S_ACCESS | one byte per cycle, bytes_left counts down to the last byte
//   S_DONE   | complete pulse (with error if the size was invalid)

module multiport_memory_controller #(
  parameter int Channels     = 4,
  parameter int AddressWidth = 16,
  parameter int Depth        = 4096,
  parameter int DataBytes    = 5,
  parameter int RoundRobin   = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [Channels-1:0]             req,
  input  logic [Channels-1:0]             we,
  input  logic [Channels*3-1:0]           size,
  input  logic [Channels*AddressWidth-1:0] addr,
  input  logic [Channels*DataBytes*8-1:0] wdata,
  output logic [Channels*DataBytes*8-1:0] rdata,
  output logic [Channels-1:0]             starting,
  output logic [Channels-1:0]             completing,
  output logic [Channels-1:0]             complete,
  output logic [Channels-1:0]             error,
  output logic                            busy
);

  localparam int CW  = (Channels > 1) ? $clog2(Channels) : 1;
  localparam int MAW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int DW  = DataBytes * 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  win_q, win_d;
  logic                           we_q, we_d;
  logic [2:0]                     size_q, size_d;
  logic [2:0]                     left_q, left_d;
  logic [AddressWidth-1:0]        addr_q, addr_d;
  logic [DW-1:0]                  wdata_q, wdata_d;
  logic                           err_q, err_d;
  logic [CW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [Channels*DW-1:0]         rdata_q, rdata_d;

  logic [7:0]                     mem_q [Depth];

  logic [CW-1:0]                  pick;
  logic                           found;
  logic [2:0]                     sel_size;
  logic [2:0]                     lane;
  int                             byte_addr;
  logic [MAW-1:0]                 mem_addr;
  logic [7:0]                     mem_rd;
  logic [7:0]                     mem_wbyte;
  logic                           mem_we;

  // Arbiter: first requesting channel, searching upward from the start index
  always_comb begin : arb_comb
    int start_idx;
    int c;
    pick      = '0;
    found     = 1'b0;
    c         = 0;
    start_idx = (RoundRobin != 0) ? int'(rr_ptr_q) : 0;
    for (int k = 0; k < Channels; k++) begin
      c = (start_idx + k) % Channels;
      if (!found && req[c]) begin
        pick  = CW'(c);
        found = 1'b1;
      end
    end
  end

  // Byte lane and wrapped memory address of the current ACCESS cycle
  always_comb begin
    lane      = size_q - 3'd1 - left_q;
    byte_addr = (int'(addr_q) + int'(lane)) % Depth;
    mem_addr  = MAW'(byte_addr);
    mem_rd    = mem_q[mem_addr];
    mem_wbyte = wdata_q[int'(lane)*8 +: 8];
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    size_d   = size_q;
    left_d   = left_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rr_ptr_d = rr_ptr_q;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    sel_size = size[int'(pick)*3 +: 3];

    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d    = pick;
          we_d     = we[pick];
          size_d   = sel_size;
          addr_d   = addr[int'(pick)*AddressWidth +: AddressWidth];
          wdata_d  = wdata[int'(pick)*DW +: DW];
          rr_ptr_d = CW'((int'(pick) + 1) % Channels);
          if (sel_size == 3'd0 || int'(sel_size) > DataBytes) begin
            // invalid size: no memory access, rdata left untouched
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            left_d  = sel_size - 3'd1;
            state_d = S_ACCESS;
            if (!we[pick]) begin
              rdata_d[int'(pick)*DW +: DW] = '0;
            end
          end
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          mem_we = 1'b1;
        end else begin
          rdata_d[int'(win_q)*DW + int'(lane)*8 +: 8] = mem_rd;
        end
        if (left_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          left_d = left_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      left_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rr_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      size_q   <= size_d;
      left_q   <= left_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory array: contents survive reset, but a write in the reset cycle is dropped
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_addr] <= mem_wbyte;
    end
  end

  // Per-channel pulses decoded from the registered state
  always_comb begin
    busy       = (state_q != S_IDLE);
    starting   = '0;
    completing = '0;
    complete   = '0;
    error      = '0;
    for (int c = 0; c < Channels; c++) begin
      if (win_q == CW'(c)) begin
        starting[c]   = (state_q == S_ACCESS) && (left_q == size_q - 3'd1);
        completing[c] = (state_q == S_ACCESS) && (left_q == 3'd0);
        complete[c]   = (state_q == S_DONE);
        error[c]      = (state_q == S_DONE) && err_q;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_multiport_memory_controller.sv
// Directed bench: one fixed-priority and one round-robin instance share all inputs.

module tb_multiport_memory_controller;

  localparam int CH = 4;
  localparam int AW = 16;
  localparam int DB = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     req, we;
  logic [CH*3-1:0]   size;
  logic [CH*AW-1:0]  addr;
  logic [CH*DB*8-1:0] wdata;

  logic [CH*DB*8-1:0] rdata_f, rdata_r;
  logic [CH-1:0]     st_f, cg_f, cp_f, er_f;
  logic [CH-1:0]     st_r, cg_r, cp_r, er_r;
  logic              busy_f, busy_r;

  int vecs = 0;
  int miss = 0;

  multiport_memory_controller #(
    .Channels(CH), .AddressWidth(AW), .Depth(4096), .DataBytes(DB), .RoundRobin(0)
  ) dut_fp (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata_f), .starting(st_f), .completing(cg_f),
    .complete(cp_f), .error(er_f), .busy(busy_f)
  );

  multiport_memory_controller #(
    .Channels(CH), .AddressWidth(AW), .Depth(4096), .DataBytes(DB), .RoundRobin(1)
  ) dut_rr (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata_r), .starting(st_r), .completing(cg_r),
    .complete(cp_r), .error(er_r), .busy(busy_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic w, input logic [2:0] s,
                        input logic [15:0] a, input logic [39:0] d);
    we[c]             = w;
    size[c*3 +: 3]    = s;
    addr[c*AW +: AW]  = a;
    wdata[c*40 +: 40] = d;
  endtask

  function automatic logic [39:0] rd_f(input int c);
    return rdata_f[c*40 +: 40];
  endfunction

  function automatic logic [39:0] rd_r(input int c);
    return rdata_r[c*40 +: 40];
  endfunction

  // Single-channel transaction on the fixed-priority instance, pulse-checked every cycle
  task automatic txn(input string tag, input int c, input logic w, input int sz,
                     input logic [15:0] a, input logic [39:0] d);
    int   last;
    bit   valid;
    logic [3:0] oh;
    valid = (sz >= 1) && (sz <= DB);
    last  = valid ? sz + 1 : 1;
    oh    = 4'(1 << c);
    set_ch(c, w, 3'(sz), a, d);
    req[c] = 1'b1;
    for (int k = 1; k <= last; k++) begin
      step();
      chk({tag, "_start"}, 64'(st_f), 64'((valid && k == 1) ? oh : 4'h0));
      chk({tag, "_compl"}, 64'(cg_f), 64'((valid && k == sz) ? oh : 4'h0));
      chk({tag, "_done"},  64'(cp_f), 64'((k == last) ? oh : 4'h0));
      chk({tag, "_err"},   64'(er_f), 64'((!valid && k == last) ? oh : 4'h0));
      chk({tag, "_busy"},  64'(busy_f), 64'h1);
      if (k == last) req[c] = 1'b0;
    end
    step();
    chk({tag, "_idle"}, 64'(busy_f), 64'h0);
  endtask

  initial begin
    req   = '0;
    we    = '0;
    size  = '0;
    addr  = '0;
    wdata = '0;
    reset = 1'b1;
    step();
    step();
    chk("rst_start", 64'(st_f), 64'h0);
    chk("rst_compl", 64'(cg_f), 64'h0);
    chk("rst_done",  64'(cp_f), 64'h0);
    chk("rst_err",   64'(er_f), 64'h0);
    chk("rst_busy",  64'(busy_f), 64'h0);
    chk("rst_rdata", 64'(|rdata_f), 64'h0);
    chk("rst_busy_rr", 64'(busy_r), 64'h0);
    reset = 1'b0;
    step();

    // write then read back, little-endian
    txn("wr1", 1, 1'b1, 4, 16'h0100, 40'h0011223344);
    txn("rd2", 2, 1'b0, 4, 16'h0100, 40'h0);
    chk("rd2_data", 64'(rd_f(2)), 64'h0011223344);
    txn("rd0b", 0, 1'b0, 1, 16'h0102, 40'h0);
    chk("rd0b_data", 64'(rd_f(0)), 64'h22);

    // fixed priority: ch0 and ch3 together
    set_ch(0, 1'b0, 3'd1, 16'h0100, 40'h0);
    set_ch(3, 1'b0, 3'd1, 16'h0103, 40'h0);
    req = 4'b1001;
    step();
    chk("fp_k1_start", 64'(st_f), 64'h1);
    chk("fp_k1_compl", 64'(cg_f), 64'h1);
    step();
    chk("fp_k2_done",  64'(cp_f), 64'h1);
    chk("fp_k2_start", 64'(st_f), 64'h0);
    chk("fp_k2_data",  64'(rd_f(0)), 64'h44);
    req[0] = 1'b0;
    step();
    chk("fp_k3_busy",  64'(busy_f), 64'h0);
    chk("fp_k3_start", 64'(st_f), 64'h0);
    step();
    chk("fp_k4_start", 64'(st_f), 64'h8);
    chk("fp_k4_compl", 64'(cg_f), 64'h8);
    step();
    chk("fp_k5_done",  64'(cp_f), 64'h8);
    chk("fp_k5_data",  64'(rd_f(3)), 64'h11);
    req[3] = 1'b0;
    step();
    chk("fp_k6_busy",  64'(busy_f), 64'h0);

    // address wrap across the top of memory
    txn("wr_wrap", 0, 1'b1, 5, 16'h0FFE, 40'h0A0B0C0D0E);
    txn("rd_wrap", 1, 1'b0, 5, 16'h0FFE, 40'h0);
    chk("rd_wrap_data", 64'(rd_f(1)), 64'h0A0B0C0D0E);
    txn("rd_zero", 3, 1'b0, 1, 16'h0000, 40'h0);
    chk("rd_zero_data", 64'(rd_f(3)), 64'h0C);
    txn("rd_hi", 3, 1'b0, 1, 16'h1001, 40'h0);
    chk("rd_hi_data", 64'(rd_f(3)), 64'h0B);

    // invalid sizes on ch2: error pulse, no memory change, rdata kept
    txn("sz0", 2, 1'b1, 0, 16'h0100, 40'hFFFFFFFFFF);
    chk("sz0_rdata", 64'(rd_f(2)), 64'h0011223344);
    txn("sz6", 2, 1'b0, 6, 16'h0100, 40'h0);
    chk("sz6_rdata", 64'(rd_f(2)), 64'h0011223344);
    txn("rd_chk", 1, 1'b0, 4, 16'h0100, 40'h0);
    chk("rd_chk_data", 64'(rd_f(1)), 64'h0011223344);

    // reset during byte 2 of a 4-byte write
    txn("pre", 3, 1'b1, 4, 16'h0200, 40'h0055555555);
    set_ch(3, 1'b1, 3'd4, 16'h0200, 40'h00A1B2C3D4);
    req[3] = 1'b1;
    step();
    chk("rw_k1_start", 64'(st_f), 64'h8);
    step();
    step();
    chk("rw_k3_busy", 64'(busy_f), 64'h1);
    reset = 1'b1;
    req   = '0;
    step();
    chk("rw_rst_start", 64'(st_f), 64'h0);
    chk("rw_rst_compl", 64'(cg_f), 64'h0);
    chk("rw_rst_done",  64'(cp_f), 64'h0);
    chk("rw_rst_err",   64'(er_f), 64'h0);
    chk("rw_rst_busy",  64'(busy_f), 64'h0);
    chk("rw_rst_rdata", 64'(|rdata_f), 64'h0);
    reset = 1'b0;
    step();
    chk("rw_post_done", 64'(cp_f), 64'h0);
    txn("rd_rst", 3, 1'b0, 4, 16'h0200, 40'h0);
    chk("rd_rst_data", 64'(rd_f(3)), 64'h005555C3D4);

    // round-robin with all channels requesting continuously
    reset = 1'b1;
    step();
    for (int c = 0; c < CH; c++) begin
      set_ch(c, 1'b0, 3'd1, 16'(16'h0100 + c), 40'h0);
    end
    reset = 1'b0;
    req   = 4'b1111;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("rr_start", 64'(st_r), 64'(((k % 3) == 1) ? 4'(1 << (((k - 1) / 3) % 4)) : 4'h0));
      if (k == 4) chk("fp_hold", 64'(st_f), 64'h1);
    end
    req = '0;
    step();
    step();
    step();
    chk("rr_idle", 64'(busy_r), 64'h0);
    chk("rr_data2", 64'(rd_r(2)), 64'h22);
    chk("rr_data3", 64'(rd_r(3)), 64'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
